traffic_ctrl_timed: RTL and testbench

Two-road (A/B) traffic-light controller, next generation of the sensor-only FSM. Green phases are tick-timed with parametrised minimum and maximum durations, plus timed yellow and all-red clearance phases. Adds a latched pedestrian request served by a walk phase and a night flashing mode. Sits between the sensor/button front end and the lamp drivers; time base is an external 1-cycle `tick` enable from a divider.

---
 rtl/traffic_ctrl_timed_if.sv | 32 +++
 rtl/traffic_ctrl_timed.sv | 143 ++++++++++++++
 tb/tb_traffic_ctrl_timed.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_ctrl_timed_if.sv
// ============================================================================
// Module      : traffic_ctrl_timed_if
// Description : Sensor/button inputs and lamp/status outputs of the timed
//               two-road traffic-light controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_ctrl_timed_if;
  logic       tick;
  logic       Ta;
  logic       Tb;
  logic       ped_req;
  logic       night_mode;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic       ped_pend;
  logic [2:0] phase;

  modport master (
    output tick, Ta, Tb, ped_req, night_mode,
    input  La, Lb, walk, ped_pend, phase
  );

  modport slave (
    input  tick, Ta, Tb, ped_req, night_mode,
    output La, Lb, walk, ped_pend, phase
  );
endinterface

`default_nettype wire

// File: rtl/traffic_ctrl_timed.sv
// ============================================================================
// Module      : traffic_ctrl_timed
// Description : Tick-timed A/B traffic-light controller with pedestrian walk
//               phase and night flashing mode; Moore outputs, registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_ctrl_timed #(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_ctrl_timed_if.slave  bus
);

  typedef enum logic [2:0] {
    S_AG    = 3'd0,
    S_AY    = 3'd1,
    S_ARB   = 3'd2,
    S_BG    = 3'd3,
    S_BY    = 3'd4,
    S_ARA   = 3'd5,
    S_WALK  = 3'd6,
    S_FLASH = 3'd7
  } state_e;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;
  localparam logic [1:0] LAMP_OFF    = 2'b11;

  // Durations widened by one bit so timer+1 never wraps before comparison.
  localparam logic [CNT_W:0]   ONE_N   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   MIN_N   = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0]   MAX_N   = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0]   YEL_N   = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0]   AR_N    = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W:0]   WALK_N  = (CNT_W+1)'(WALK_T);
  localparam logic [CNT_W-1:0] TMR_MAX = '1;
  localparam logic [CNT_W-1:0] TMR_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             blink_q, blink_d;
  logic             ped_pend_q, ped_pend_d;
  logic [1:0]       la_q, la_d;
  logic [1:0]       lb_q, lb_d;
  logic             walk_q, walk_d;
  logic [CNT_W:0]   n;

  always_comb begin
    state_d = state_q;
    n       = {1'b0, timer_q} + ONE_N;

    case (state_q)
      S_AG:    if (bus.tick && ((n >= MIN_N && (!bus.Ta || bus.night_mode)) ||
                                (n >= MAX_N && bus.Tb)))
                 state_d = S_AY;
      S_AY:    if (bus.tick && n == YEL_N) state_d = S_ARB;
      S_ARB:   if (bus.tick && n == AR_N)
                 state_d = bus.night_mode ? S_FLASH : S_BG;
      S_BG:    if (bus.tick && ((n >= MIN_N && (!bus.Tb || bus.night_mode)) ||
                                (n >= MAX_N && bus.Ta)))
                 state_d = S_BY;
      S_BY:    if (bus.tick && n == YEL_N) state_d = S_ARA;
      S_ARA:   if (bus.tick && n == AR_N) begin
                 if (bus.night_mode)  state_d = S_FLASH;
                 else if (ped_pend_q) state_d = S_WALK;
                 else                 state_d = S_AG;
               end
      S_WALK:  if (bus.tick && n == WALK_N) state_d = S_AG;
      S_FLASH: if (bus.tick && !bus.night_mode) state_d = S_ARA;
      default: state_d = S_ARA;
    endcase

    if (state_d != state_q)                  timer_d = '0;
    else if (bus.tick && timer_q != TMR_MAX) timer_d = timer_q + TMR_ONE;
    else                                     timer_d = timer_q;

    if (state_d != state_q)                  blink_d = 1'b0;
    else if (bus.tick && state_q == S_FLASH) blink_d = ~blink_q;
    else                                     blink_d = blink_q;

    // Entering WALK serves the request and swallows a same-cycle press.
    if (state_d == S_WALK && state_q != S_WALK) ped_pend_d = 1'b0;
    else                                        ped_pend_d = ped_pend_q | bus.ped_req;

    la_d   = LAMP_RED;
    lb_d   = LAMP_RED;
    walk_d = 1'b0;
    case (state_d)
      S_AG:    la_d = LAMP_GREEN;
      S_AY:    la_d = LAMP_YELLOW;
      S_BG:    lb_d = LAMP_GREEN;
      S_BY:    lb_d = LAMP_YELLOW;
      S_WALK:  walk_d = 1'b1;
      S_FLASH: begin
        if (blink_d) begin
          la_d = LAMP_OFF;
          lb_d = LAMP_OFF;
        end else begin
          la_d = LAMP_YELLOW;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ARA;
      timer_q    <= '0;
      blink_q    <= 1'b0;
      ped_pend_q <= 1'b0;
      la_q       <= LAMP_RED;
      lb_q       <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      blink_q    <= blink_d;
      ped_pend_q <= ped_pend_d;
      la_q       <= la_d;
      lb_q       <= lb_d;
      walk_q     <= walk_d;
    end
  end

  assign bus.La       = la_q;
  assign bus.Lb       = lb_q;
  assign bus.walk     = walk_q;
  assign bus.ped_pend = ped_pend_q;
  assign bus.phase    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_ctrl_timed.sv
// ============================================================================
// Module      : tb_traffic_ctrl_timed
// Description : Directed and randomized bench for traffic_ctrl_timed against a
//               phase/duration-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_ctrl_timed;
  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 8;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 3;

  localparam int AG = 0, AY = 1, ARB = 2, BG = 3, BY = 4, ARA = 5, WLK = 6, FLASH = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;

  traffic_ctrl_timed_if bus ();

  traffic_ctrl_timed #(
    .CNT_W(8), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, ticks spent in phase, pending ped, blink.
  int m_phase = ARA;
  int m_cnt   = 0;
  bit m_ped   = 1'b0;
  bit m_blink = 1'b0;
  int fixed_dur [8] = '{0, YELLOW_T, ALLRED_T, 0, YELLOW_T, ALLRED_T, WALK_T, 0};
  int nxt, ticks;

  function automatic int after_fixed(int ph, bit night, bit ped);
    case (ph)
      AY:      return ARB;
      ARB:     return night ? FLASH : BG;
      BY:      return ARA;
      ARA:     return night ? FLASH : (ped ? WLK : AG);
      default: return AG;
    endcase
  endfunction

  function automatic logic [3:0] lamps(int ph, bit bl);
    case (ph)
      AG:      return 4'b00_10;
      AY:      return 4'b01_10;
      BG:      return 4'b10_00;
      BY:      return 4'b10_01;
      FLASH:   return bl ? 4'b11_11 : 4'b01_10;
      default: return 4'b10_10;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = ARA; m_cnt = 0; m_ped = 1'b0; m_blink = 1'b0;
    end else begin
      nxt   = m_phase;
      ticks = m_cnt + 1;
      if (bus.tick) begin
        if (fixed_dur[m_phase] != 0) begin
          if (ticks == fixed_dur[m_phase]) nxt = after_fixed(m_phase, bus.night_mode, m_ped);
        end else if (m_phase == AG) begin
          if ((ticks >= MIN_GREEN && (!bus.Ta || bus.night_mode)) || (ticks >= MAX_GREEN && bus.Tb)) nxt = AY;
        end else if (m_phase == BG) begin
          if ((ticks >= MIN_GREEN && (!bus.Tb || bus.night_mode)) || (ticks >= MAX_GREEN && bus.Ta)) nxt = BY;
        end else if (!bus.night_mode) begin
          nxt = ARA;
        end
      end
      if (bus.ped_req) m_ped = 1'b1;
      if (nxt != m_phase) begin
        m_cnt = 0; m_blink = 1'b0;
        if (nxt == WLK) m_ped = 1'b0;
      end else if (bus.tick) begin
        m_cnt++;
        if (m_phase == FLASH) m_blink = ~m_blink;
      end
      m_phase = nxt;
    end
  end

  logic [3:0] exp_l;
  always @(negedge clk) begin
    if (checking) begin
      exp_l = lamps(m_phase, m_blink);
      n_cmp++;
      if ({bus.La, bus.Lb} !== exp_l || bus.walk !== (m_phase == WLK) ||
          bus.ped_pend !== m_ped || bus.phase !== 3'(m_phase)) begin
        n_bad++;
        $display("FAIL model t=%0t: got La=%b Lb=%b walk=%b ped=%b phase=%0d, expected La=%b Lb=%b walk=%b ped=%b phase=%0d",
                 $time, bus.La, bus.Lb, bus.walk, bus.ped_pend, bus.phase,
                 exp_l[3:2], exp_l[1:0], (m_phase == WLK), m_ped, m_phase);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input bit t, input bit a, input bit b, input bit p, input bit nm);
    @(negedge clk);
    bus.tick = t; bus.Ta = a; bus.Tb = b; bus.ped_req = p; bus.night_mode = nm;
  endtask

  // One tick followed by three idle clocks; outputs settled on return.
  task automatic do_tick(input bit a, input bit b, input bit p, input bit nm);
    cyc(1'b1, a, b, p, nm);
    repeat (3) cyc(1'b0, a, b, 1'b0, nm);
  endtask

  task automatic ticks_n(input int cnt, input bit a, input bit b, input bit nm);
    for (int i = 0; i < cnt; i++) do_tick(a, b, 1'b0, nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.tick = 1'b0; bus.ped_req = 1'b0;
    @(negedge clk);
    checking = 1'b1;
    chk("reset_phase", 8'(bus.phase), 8'd5);
    chk("reset_La", 8'(bus.La), 8'd2);
    chk("reset_Lb", 8'(bus.Lb), 8'd2);
    chk("reset_ped", 8'(bus.ped_pend), 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.Ta = 1'b0; bus.Tb = 1'b0; bus.ped_req = 1'b0; bus.night_mode = 1'b0;
    do_reset();

    // ARA for one tick, then AG that holds while only A has traffic
    do_tick(1, 0, 0, 0);
    chk("ara_to_ag", 8'(bus.phase), 8'd0);
    chk("ag_La_green", 8'(bus.La), 8'd0);
    ticks_n(10, 1, 0, 0);
    chk("ag_holds", 8'(bus.phase), 8'd0);
    do_tick(0, 0, 0, 0);
    chk("ag_to_ay", 8'(bus.phase), 8'd1);
    ticks_n(2, 0, 0, 0);
    chk("ay_to_arb", 8'(bus.phase), 8'd2);
    do_tick(0, 0, 0, 0);
    chk("arb_to_bg", 8'(bus.phase), 8'd3);

    // pedestrian walk after BG
    do_tick(0, 0, 1, 0);
    chk("ped_latched", 8'(bus.ped_pend), 8'd1);
    ticks_n(2, 0, 0, 0);
    chk("bg_min", 8'(bus.phase), 8'd3);
    do_tick(0, 0, 0, 0);
    chk("bg_to_by", 8'(bus.phase), 8'd4);
    ticks_n(2, 0, 0, 0);
    chk("by_to_ara", 8'(bus.phase), 8'd5);
    do_tick(0, 0, 0, 0);
    chk("ara_to_walk", 8'(bus.phase), 8'd6);
    chk("walk_lamp", 8'(bus.walk), 8'd1);
    chk("ped_served", 8'(bus.ped_pend), 8'd0);
    ticks_n(2, 0, 0, 0);
    chk("walk_hold", 8'(bus.phase), 8'd6);
    do_tick(1, 1, 0, 0);
    chk("walk_to_ag", 8'(bus.phase), 8'd0);

    // MAX_GREEN force with both roads busy
    ticks_n(7, 1, 1, 0);
    chk("ag_before_max", 8'(bus.phase), 8'd0);
    do_tick(1, 1, 0, 0);
    chk("ag_max_force", 8'(bus.phase), 8'd1);
    ticks_n(3, 1, 1, 0);
    chk("to_bg_again", 8'(bus.phase), 8'd3);

    // night mode from BG into FLASH and back
    do_tick(1, 1, 0, 0);
    ticks_n(2, 1, 1, 1);
    chk("bg_night_min", 8'(bus.phase), 8'd3);
    do_tick(1, 1, 0, 1);
    chk("bg_night_exit", 8'(bus.phase), 8'd4);
    ticks_n(3, 1, 1, 1);
    chk("flash_enter", 8'(bus.phase), 8'd7);
    chk("flash_La0", 8'(bus.La), 8'd1);
    chk("flash_Lb0", 8'(bus.Lb), 8'd2);
    do_tick(1, 1, 0, 1);
    chk("flash_La1", 8'(bus.La), 8'd3);
    chk("flash_Lb1", 8'(bus.Lb), 8'd3);
    do_tick(1, 1, 0, 1);
    chk("flash_La2", 8'(bus.La), 8'd1);
    do_tick(1, 0, 0, 0);
    chk("flash_to_ara", 8'(bus.phase), 8'd5);
    do_tick(1, 0, 0, 0);
    chk("ara_to_ag2", 8'(bus.phase), 8'd0);

    // sensors toggled only between ticks must not disturb timing
    ticks_n(3, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    chk("nontick_hold", 8'(bus.phase), 8'd0);
    do_tick(0, 0, 0, 0);
    chk("ag_exact4", 8'(bus.phase), 8'd1);
    ticks_n(3, 0, 0, 0);
    ticks_n(4, 0, 0, 0);
    chk("reach_by", 8'(bus.phase), 8'd4);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ped_in_by", 8'(bus.ped_pend), 8'd1);
    do_reset();

    // randomized run
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      bus.tick = ($urandom_range(0, 2) == 0);
      bus.Ta = 1'($urandom);
      bus.Tb = 1'($urandom);
      bus.ped_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) bus.night_mode = ~bus.night_mode;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
